atm_txn_ctrl: RTL and testbench

//  Transaction controller upstream of the account balance counter. Sequences card insert,
//  PIN check, deposit/withdraw selection and amount entry. Issues single-cycle inc/dec

---
 rtl/atm_pkg.sv | 28 ++
 rtl/atm_timeout_timer.sv | 30 +++
 rtl/atm_txn_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_atm_txn_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM transaction controller:
// FSM states, operation select and error codes.
package atm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_MENU,
    S_AMOUNT,
    S_CHECK,
    S_ISSUE,
    S_VERIFY,
    S_LOCK
  } state_t;

  typedef enum logic {
    OP_DEP,
    OP_WD
  } op_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PIN     = 3'd1;
  localparam logic [2:0] ERR_FUNDS   = 3'd2;
  localparam logic [2:0] ERR_OVF     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_LIMIT   = 3'd5;

endpackage

// File: rtl/atm_timeout_timer.sv
// Idle timer: cleared by load, flags expiry after TIMEOUT
// unloaded cycles. A load in the expiry cycle wins.
module atm_timeout_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;
  logic         at_end;

  assign at_end = (cnt == W'(TIMEOUT - 1));
  assign expire = at_end && !load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (!at_end) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM transaction sequencer driving the balance counter.
// Define ATM_WD_LIMIT_EN to enable the per-session withdraw cap.
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter logic [15:0] PIN_CODE  = 16'h1234,
  parameter int          MAX_TRIES = 3,
  parameter int          TIMEOUT   = 1000,
  parameter logic [7:0]  WD_LIMIT  = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        pin_vld,
  input  logic [15:0] pin,
  input  logic        op_dep,
  input  logic        op_wd,
  input  logic        amt_vld,
  input  logic [7:0]  amt,
  input  logic [7:0]  balance,
  output logic        inc,
  output logic        dec,
  output logic [7:0]  amount,
  output logic        card_eject,
  output logic        locked,
  output logic        txn_ok,
  output logic        txn_err,
  output logic [2:0]  err_code
);

  localparam logic [2:0] TRY_MAX = 3'(MAX_TRIES);

  state_t     state;
  op_t        op;
  logic [2:0] tries;
  logic [7:0] expect_bal;
  logic [2:0] chk_err;
  logic [8:0] dep_sum;
  logic       timed;
  logic       strobe;
  logic       expire;

  assign timed   = (state == S_PIN) || (state == S_MENU)
                || (state == S_AMOUNT);
  assign strobe  = pin_vld || op_dep || op_wd || amt_vld;
  assign dep_sum = {1'b0, balance} + {1'b0, amount};

  atm_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (!timed || strobe),
    .expire(expire)
  );

`ifdef ATM_WD_LIMIT_EN
  logic [8:0] wd_sum;
  logic [9:0] lim_sum;
  assign lim_sum = {1'b0, wd_sum} + {2'b0, amount};
`endif

  always_comb begin
    chk_err = ERR_NONE;
    if (op == OP_DEP) begin
      if (amount == 8'd0 || dep_sum[8]) chk_err = ERR_OVF;
    end else if (amount == 8'd0 || amount > balance) begin
      chk_err = ERR_FUNDS;
    end
`ifdef ATM_WD_LIMIT_EN
    else if (lim_sum > {2'b0, WD_LIMIT}) begin
      chk_err = ERR_LIMIT;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op         <= OP_DEP;
      tries      <= '0;
      expect_bal <= '0;
      amount     <= '0;
      inc        <= 1'b0;
      dec        <= 1'b0;
      card_eject <= 1'b0;
      locked     <= 1'b0;
      txn_ok     <= 1'b0;
      txn_err    <= 1'b0;
      err_code   <= ERR_NONE;
`ifdef ATM_WD_LIMIT_EN
      wd_sum     <= '0;
`endif
    end else begin
      inc        <= 1'b0;
      dec        <= 1'b0;
      card_eject <= 1'b0;
      txn_ok     <= 1'b0;
      txn_err    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tries <= '0;
`ifdef ATM_WD_LIMIT_EN
          wd_sum <= '0;
`endif
          if (card_in) state <= S_PIN;
        end
        S_PIN: begin
          if (!card_in) begin
            state <= S_IDLE;
          end else if (expire) begin
            card_eject <= 1'b1;
            err_code   <= ERR_TIMEOUT;
            state      <= S_IDLE;
          end else if (pin_vld) begin
            if (pin == PIN_CODE) begin
              tries <= '0;
              state <= S_MENU;
            end else begin
              txn_err  <= 1'b1;
              err_code <= ERR_PIN;
              tries    <= tries + 3'd1;
              // Card is retained once tries run out
              if (tries + 3'd1 == TRY_MAX) begin
                locked <= 1'b1;
                state  <= S_LOCK;
              end
            end
          end
        end
        S_MENU: begin
          if (!card_in || expire) begin
            card_eject <= 1'b1;
            if (card_in) err_code <= ERR_TIMEOUT;
            state <= S_IDLE;
          end else if (op_dep) begin
            op    <= OP_DEP;
            state <= S_AMOUNT;
          end else if (op_wd) begin
            op    <= OP_WD;
            state <= S_AMOUNT;
          end
        end
        S_AMOUNT: begin
          if (!card_in) begin
            state <= S_IDLE;
          end else if (expire) begin
            card_eject <= 1'b1;
            err_code   <= ERR_TIMEOUT;
            state      <= S_IDLE;
          end else if (amt_vld) begin
            amount <= amt;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!card_in) begin
            state <= S_IDLE;
          end else if (chk_err != ERR_NONE) begin
            txn_err  <= 1'b1;
            err_code <= chk_err;
            state    <= S_MENU;
          end else begin
            expect_bal <= (op == OP_DEP) ? balance + amount
                                         : balance - amount;
            inc   <= (op == OP_DEP);
            dec   <= (op == OP_WD);
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_VERIFY;
        S_VERIFY: begin
          if (balance == expect_bal) begin
            txn_ok   <= 1'b1;
            err_code <= ERR_NONE;
`ifdef ATM_WD_LIMIT_EN
            if (op == OP_WD) wd_sum <= wd_sum + {1'b0, amount};
`endif
          end else begin
            txn_err  <= 1'b1;
            err_code <= ERR_OVF;
          end
          state <= S_MENU;
        end
        S_LOCK: locked <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Directed bench for atm_txn_ctrl with a behavioural balance
// counter; build with ATM_WD_LIMIT_EN to check the withdraw cap.
module tb_atm_txn_ctrl;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        card_in = 1'b0;
  logic        pin_vld = 1'b0;
  logic [15:0] pin = '0;
  logic        op_dep = 1'b0;
  logic        op_wd = 1'b0;
  logic        amt_vld = 1'b0;
  logic [7:0]  amt = '0;
  logic [7:0]  balance;
  logic        inc, dec, card_eject, locked, txn_ok, txn_err;
  logic [7:0]  amount;
  logic [2:0]  err_code;

  logic [7:0]  bal = '0;
  logic [7:0]  bal_init = '0;
  logic        bal_ld = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int n_inc, n_dec, n_both, n_ok, n_err, n_ej;
  logic [7:0] pulse_amt;
  logic [2:0] last_err, ej_err;

  assign balance = bal;

  atm_txn_ctrl #(
    .PIN_CODE (16'h1234),
    .MAX_TRIES(3),
    .TIMEOUT  (TO),
    .WD_LIMIT (8'd200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .card_in   (card_in),
    .pin_vld   (pin_vld),
    .pin       (pin),
    .op_dep    (op_dep),
    .op_wd     (op_wd),
    .amt_vld   (amt_vld),
    .amt       (amt),
    .balance   (balance),
    .inc       (inc),
    .dec       (dec),
    .amount    (amount),
    .card_eject(card_eject),
    .locked    (locked),
    .txn_ok    (txn_ok),
    .txn_err   (txn_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Account counter: applies a pulse on the edge that samples it
  always @(posedge clk) begin
    if (bal_ld) bal <= bal_init;
    else if (inc) bal <= bal + amount;
    else if (dec) bal <= bal - amount;
  end

  always @(negedge clk) begin
    if (inc) begin n_inc++; pulse_amt = amount; end
    if (dec) begin n_dec++; pulse_amt = amount; end
    if (inc && dec) n_both++;
    if (txn_ok) n_ok++;
    if (txn_err) begin n_err++; last_err = err_code; end
    if (card_eject) begin n_ej++; ej_err = err_code; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clr_mon();
    n_inc = 0; n_dec = 0; n_ok = 0; n_err = 0; n_ej = 0;
    pulse_amt = '0; last_err = '0; ej_err = '0;
  endtask

  task automatic load_bal(input logic [7:0] v);
    bal_init = v; bal_ld = 1'b1; step(); bal_ld = 1'b0;
  endtask

  task automatic do_pin(input logic [15:0] v);
    pin = v; pin_vld = 1'b1; step(); pin_vld = 1'b0;
  endtask

  task automatic do_op(input logic d, input logic w);
    op_dep = d; op_wd = w; step(); op_dep = 1'b0; op_wd = 1'b0;
  endtask

  task automatic do_amt(input logic [7:0] v);
    amt = v; amt_vld = 1'b1; step(); amt_vld = 1'b0;
  endtask

  task automatic session_start();
    card_in = 1'b1; run(2); do_pin(16'h1234);
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({inc, dec, card_eject, locked, txn_ok, txn_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000",
        {inc, dec, card_eject, locked, txn_ok, txn_err});
    end
    n_tests++;
    if (amount !== 8'd0 || err_code !== 3'd0) begin
      n_fail++; $display("FAIL reset_data: amount %0d err %0d want 0 0",
        amount, err_code);
    end
    load_bal(8'd0);
    run(2);
    rst = 1'b1;
    step();
  endtask

  task automatic test_deposit();
    session_start();
    clr_mon();
    do_op(1'b1, 1'b0);
    do_amt(8'd50);
    run(6);
    n_tests++;
    if (n_inc !== 1 || n_dec !== 0) begin
      n_fail++; $display("FAIL dep_pulse: inc %0d dec %0d want 1 0", n_inc, n_dec);
    end
    n_tests++;
    if (pulse_amt !== 8'd50) begin
      n_fail++; $display("FAIL dep_amount: got %0d want 50", pulse_amt);
    end
    n_tests++;
    if (bal !== 8'd50 || n_ok !== 1 || n_err !== 0) begin
      n_fail++; $display("FAIL dep_result: bal %0d ok %0d err %0d want 50 1 0",
        bal, n_ok, n_err);
    end
  endtask

  task automatic test_insufficient();
    load_bal(8'd30);
    clr_mon();
    do_op(1'b0, 1'b1);
    do_amt(8'd40);
    run(5);
    n_tests++;
    if (n_err !== 1 || last_err !== 3'd2 || n_dec !== 0) begin
      n_fail++; $display("FAIL wd_funds: err %0d code %0d dec %0d want 1 2 0",
        n_err, last_err, n_dec);
    end
    clr_mon();
    do_op(1'b1, 1'b0);
    do_amt(8'd5);
    run(5);
    n_tests++;
    if (n_inc !== 1 || bal !== 8'd35) begin
      n_fail++; $display("FAIL funds_back_to_menu: inc %0d bal %0d want 1 35",
        n_inc, bal);
    end
  endtask

  task automatic test_overflow();
    load_bal(8'd250);
    clr_mon();
    do_op(1'b1, 1'b0);
    do_amt(8'd10);
    run(5);
    n_tests++;
    if (n_err !== 1 || last_err !== 3'd3 || n_inc !== 0) begin
      n_fail++; $display("FAIL dep_overflow: err %0d code %0d inc %0d want 1 3 0",
        n_err, last_err, n_inc);
    end
    clr_mon();
    do_op(1'b1, 1'b0);
    do_amt(8'd5);
    run(5);
    n_tests++;
    if (n_inc !== 1 || bal !== 8'd255 || n_ok !== 1) begin
      n_fail++; $display("FAIL dep_to_255: inc %0d bal %0d ok %0d want 1 255 1",
        n_inc, bal, n_ok);
    end
  endtask

  task automatic test_timeout();
    clr_mon();
    run(TO - 10);
    n_tests++;
    if (n_ej !== 0) begin
      n_fail++; $display("FAIL timeout_early: eject %0d want 0", n_ej);
    end
    run(20);
    n_tests++;
    if (n_ej !== 1 || ej_err !== 3'd4) begin
      n_fail++; $display("FAIL timeout_eject: eject %0d code %0d want 1 4",
        n_ej, ej_err);
    end
  endtask

  task automatic test_lockout();
    clr_mon();
    for (int i = 0; i < 3; i++) begin
      do_pin(16'h0000);
      step();
    end
    n_tests++;
    if (n_err !== 3 || last_err !== 3'd1) begin
      n_fail++; $display("FAIL bad_pin: err %0d code %0d want 3 1", n_err, last_err);
    end
    n_tests++;
    if (locked !== 1'b1 || n_ej !== 0 || n_inc !== 0 || n_dec !== 0) begin
      n_fail++; $display("FAIL lock_set: locked %b eject %0d inc %0d dec %0d want 1 0 0 0",
        locked, n_ej, n_inc, n_dec);
    end
    card_in = 1'b0;
    run(20);
    n_tests++;
    if (locked !== 1'b1 || n_ej !== 0) begin
      n_fail++; $display("FAIL lock_hold: locked %b eject %0d want 1 0", locked, n_ej);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_reset: locked %b want 0", locked);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_card_removed();
    session_start();
    clr_mon();
    card_in = 1'b0;
    run(3);
    n_tests++;
    if (n_ej !== 1 || n_err !== 0) begin
      n_fail++; $display("FAIL menu_removed: eject %0d err %0d want 1 0", n_ej, n_err);
    end
  endtask

  task automatic test_wd_limit();
    session_start();
    load_bal(8'd250);
    clr_mon();
    do_op(1'b0, 1'b1);
    do_amt(8'd150);
    run(5);
    n_tests++;
    if (n_dec !== 1 || n_ok !== 1 || bal !== 8'd100 || pulse_amt !== 8'd150) begin
      n_fail++; $display("FAIL wd_150: dec %0d ok %0d bal %0d amt %0d want 1 1 100 150",
        n_dec, n_ok, bal, pulse_amt);
    end
    clr_mon();
    do_op(1'b0, 1'b1);
    do_amt(8'd60);
    run(5);
`ifdef ATM_WD_LIMIT_EN
    n_tests++;
    if (n_err !== 1 || last_err !== 3'd5 || n_dec !== 0 || bal !== 8'd100) begin
      n_fail++; $display("FAIL wd_limit: err %0d code %0d dec %0d bal %0d want 1 5 0 100",
        n_err, last_err, n_dec, bal);
    end
`else
    n_tests++;
    if (n_ok !== 1 || n_dec !== 1 || bal !== 8'd40) begin
      n_fail++; $display("FAIL wd_nolimit: ok %0d dec %0d bal %0d want 1 1 40",
        n_ok, n_dec, bal);
    end
`endif
  endtask

  task automatic test_dep_priority();
    logic [7:0] b0;
    b0 = bal;
    clr_mon();
    do_op(1'b1, 1'b1);
    do_amt(8'd5);
    run(5);
    n_tests++;
    if (n_inc !== 1 || n_dec !== 0 || bal !== b0 + 8'd5) begin
      n_fail++; $display("FAIL dep_wins: inc %0d dec %0d bal %0d want 1 0 %0d",
        n_inc, n_dec, bal, b0 + 8'd5);
    end
  endtask

  task automatic test_async_reset_issue();
    load_bal(8'd0);
    do_op(1'b1, 1'b0);
    do_amt(8'd20);
    step();
    n_tests++;
    if (inc !== 1'b1 || amount !== 8'd20) begin
      n_fail++; $display("FAIL issue_reached: inc %b amount %0d want 1 20", inc, amount);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({inc, dec, card_eject, locked, txn_ok, txn_err} !== 6'b0
        || amount !== 8'd0 || err_code !== 3'd0) begin
      n_fail++; $display("FAIL async_reset: flags %b amount %0d err %0d want 0 0 0",
        {inc, dec, card_eject, locked, txn_ok, txn_err}, amount, err_code);
    end
    step();
    rst = 1'b1;
    run(3);
    n_tests++;
    if (bal !== 8'd0) begin
      n_fail++; $display("FAIL reset_no_pulse: bal %0d want 0", bal);
    end
  endtask

  initial begin
    n_both = 0;
    clr_mon();
    test_reset();
    test_deposit();
    test_insufficient();
    test_overflow();
    test_timeout();
    test_lockout();
    test_card_removed();
    test_wd_limit();
    test_dep_priority();
    test_async_reset_issue();
    n_tests++;
    if (n_both !== 0) begin
      n_fail++; $display("FAIL inc_dec_overlap: got %0d want 0", n_both);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
